// File: rtl/priority_encoder_q.sv
// Registered priority encoder: collects request bits into a pending vector and offers one
// binary index at a time over valid/ready, lowest- or highest-index first.
`timescale 1ns/1ps

module priority_encoder_q #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic [IDX_W:0]   pend_cnt,
    output logic             multi_hit
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] grant;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             multi_q, multi_d;
    logic             accept;

    function automatic logic [IDX_W-1:0] enc(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        // The last match in scan order wins, so scan away from the priority end.
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (v[i]) r = IDX_W'(i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (v[i]) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction

    assign accept = (state_q == ST_OFFER) && out_ready;

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            grant[i] = accept && (idx_q == IDX_W'(i));
        end
    end

    // Set wins over clear: a re-request on the accepted bit keeps it pending.
    assign pend_d  = (pend_q & ~grant) | in_req;
    assign cnt_d   = popcnt(pend_d);
    assign multi_d = popcnt(in_req) > (IDX_W+1)'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_d) begin
                    state_d = ST_OFFER;
                    idx_d   = enc(pend_d);
                end
            end
            ST_OFFER: begin
                // Without an accept the offer is frozen, even if higher priority arrives.
                if (accept) begin
                    if (|pend_d) begin
                        idx_d = enc(pend_d);
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            multi_q <= multi_d;
        end
    end

    assign out_valid = (state_q == ST_OFFER);
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign pend_cnt  = cnt_q;
    assign multi_hit = multi_q;

endmodule

// File: doc/priority_encoder_q.md
# priority_encoder_q

Parametrised, registered priority encoder with request queuing. Successor to the fixed 4-to-2 combinational encoder in the encoder/decoder library. It collects request bits from a WIDTH-bit input into a pending register and offers one binary index at a time over a valid/ready handshake, in a selectable priority order. Unlike the combinational encoder, it has no undefined output for multi-hot inputs: every set bit is eventually served, and multi-hot inputs are flagged.

## Interface
- WIDTH, default 8: number of request lines. Legal range is ≥ 2; powers of two are not required.
- MSB_FIRST, default 0: 0 = lowest index has priority; 1 = highest index has priority.
- IDX_W, localparam = $clog2(WIDTH): width of out_idx.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_req, input, WIDTH: request bits, sampled every rising edge. Any number of bits may be set.
- out_valid, output, 1: registered; an index is on offer.
- out_idx, output, IDX_W: registered; binary index of the offered request.
- out_ready, input, 1: consumer accepts the offer. accept = out_valid && out_ready.
- pending, output, WIDTH: registered pending-request vector P.
- pend_cnt, output, IDX_W+1: registered popcount of P.
- multi_hit, output, 1: registered pulse; the in_req sampled at the previous edge had more than 1 bit set.

## Operation
- Grant mask G = accept ? onehot(out_idx) : 0.
- Pending update: P_next = (P & ~G) | in_req. Set wins over clear: a request re-asserted on the bit being accepted stays pending.
- Two-state offer FSM:
  - IDLE (out_valid = 0): if P_next != 0, go to OFFER with out_idx = enc(P_next). Otherwise stay in IDLE.
  - OFFER (out_valid = 1):
    - No accept: hold. out_idx stays stable even if a higher-priority request arrives.
    - Accept with P_next != 0: stay in OFFER and load out_idx = enc(P_next).
    - Accept with P_next = 0: go to IDLE.
- enc() rules:
  - MSB_FIRST = 0 selects the lowest set index.
  - MSB_FIRST = 1 selects the highest set index.
  - The offered bit always remains set in P until it is accepted.
- pend_cnt_next = popcount(P_next).
- multi_hit_next = (popcount(in_req) > 1).
- out_idx is 0 whenever out_valid = 0.
- out_ready while out_valid = 0 is ignored.
- in_req = 0 causes no state change other than grant clearing.
- With WIDTH = 4, MSB_FIRST = 0, and one-hot single-cycle inputs served immediately, out_idx matches the legacy 4-to-2 mapping: 0001→0, 0010→1, 0100→2, 1000→3.

## Timing
- Reset (rst_n low at a rising edge):
  - P = 0, pend_cnt = 0, multi_hit = 0, out_valid = 0, out_idx = 0, FSM = IDLE.
  - in_req at that edge is discarded.
  - Reset mid-offer drops the offer and all pending requests with no accept.
- Latency: in_req sampled at edge k gives out_valid = 1 and the corresponding out_idx after edge k (1 cycle), provided the FSM was in IDLE or accepting at edge k.
- Throughput: with out_ready held high, one index is accepted per cycle and there are no bubbles while P_next != 0.
- Simultaneous events at one edge (accept, new requests on other bits, re-request on the granted bit) are all resolved by the P_next equation above.
- A request held high continuously is re-offered indefinitely. In LSB-first mode it can starve higher bits; this is by design, and the team uses an arbiter when fairness is required.
- Bits already set in P that are re-requested do not change state (they are not counted twice).

## Test plan
- Reset and idle: hold rst_n = 0 for 2 cycles with in_req = 8'hFF. Required: all outputs 0. Release reset with in_req = 0. Required: out_valid stays 0 and pend_cnt = 0.
- One-hot sweep (WIDTH = 8, MSB_FIRST = 0, out_ready = 1): drive in_req = 1 << i for i = 0..7, one per cycle. Required: after each edge, out_idx = i and out_valid = 1; multi_hit never asserts.
- Multi-hot drain: one-cycle pulse in_req = 8'b1010_0110 with out_ready = 1.
  - Required: multi_hit = 1 for one cycle, pend_cnt = 4.
  - Required: out_idx sequence 1, 2, 5, 7 on consecutive cycles, then out_valid = 0.
  - With MSB_FIRST = 1 the sequence is 7, 5, 2, 1.
- Backpressure stability: offer out_idx = 3 with out_ready = 0, then pulse in_req = 8'h01. Required: out_idx stays 3 for all stall cycles and pending = 8'h09. After out_ready = 1, the next offer is 0.
- Set-wins collision: while out_idx = 4 is accepted, drive in_req = 8'h10 on the same edge. Required: bit 4 remains in pending, out_idx = 4 is offered again next cycle, and pend_cnt is unchanged.
- Mid-operation reset: with pending = 8'hF0 and out_valid = 1, assert rst_n = 0 for one edge. Required: all outputs 0 next cycle and no stale index offered afterwards.
